uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
Transmit controller for the CPU's serial output line `uart_tx`. It accepts byte writes from the CPU store path into an internal FIFO and drains them one frame at a time. Each frame is 8N1: start bit, 8 data bits LSB first, stop bit, with a programmable bit period. It sits between the memory-mapped I/O decode and the top-level `uart_tx` pin, so the CPU never stalls on serial timing unless the FIFO is full.

Parameters:
- CLKS_PER_BIT, 868: sysclk cycles per serial bit (100 MHz / 115200). Must be ≥ 2.
- FIFO_AW, 4: FIFO address width. Depth = 2**FIFO_AW entries.

Ports:
- sysclk  input  1  system clock, all logic on rising edge.
- cpu_resetn  input  1  asynchronous active-low reset.
- wr_en  input  1  CPU write strobe, one byte per cycle when high.
- wr_data  input  8  byte to transmit.
- full  output  1  FIFO holds 2**FIFO_AW entries.
- empty  output  1  FIFO holds 0 entries.
- busy  output  1  FSM not in IDLE, or FIFO not empty.
- overflow  output  1  sticky: a write arrived while full.
- uart_tx  output  1  registered serial line, idle high.

Behaviour:
- Reset (async, cpu_resetn=0): state=IDLE, uart_tx=1, FIFO pointers and count=0, full=0, empty=1, busy=0, overflow=0, bit counter=0, baud counter=0. Reset mid-frame aborts the frame immediately: uart_tx=1 and all queued bytes are discarded.
- FIFO:
  - Circular buffer with FIFO_AW-bit read/write pointers that wrap modulo depth.
  - count is FIFO_AW+1 bits wide; full = (count == depth), empty = (count == 0). Both are combinational from the registered count.
  - Write accepted iff wr_en && !full. Write when full is dropped, sets overflow=1, and leaves FIFO contents unchanged. This holds even if a pop occurs in the same cycle.
  - A simultaneous accepted write and pop leaves count unchanged and updates both pointers.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: uart_tx=1. If !empty: pop head into shift register, load baud counter with CLKS_PER_BIT-1, go to START, drive uart_tx=0 on the same edge.
  - START: uart_tx=0 for CLKS_PER_BIT cycles. When baud counter reaches 0: reload it, bit counter=0, go to DATA, drive uart_tx=shift[0].
  - DATA: hold the current bit for CLKS_PER_BIT cycles. At counter 0: shift right and increment bit counter. After bit 7 completes, go to STOP with uart_tx=1; otherwise drive the next bit.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles. At counter 0:
    - if !empty, pop and go directly to START (back-to-back frames, no idle gap);
    - otherwise go to IDLE.
- Latency: a byte written at edge k into an empty FIFO with the FSM in IDLE pops at edge k+1, so uart_tx falls at edge k+1. A full frame lasts 10*CLKS_PER_BIT cycles.
- busy drops only after the last stop bit completes and the FIFO is empty.
- overflow is cleared only by reset.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: adds a PARITY state between DATA and STOP.
  - It transmits the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame becomes 11*CLKS_PER_BIT cycles (8E1).
  - Parity is computed from the byte at pop time and held in a register.
- Undefined: no PARITY state and no parity register; 8N1 only.

Test Plan:
- Reset behaviour: hold cpu_resetn=0 for 3 cycles, then release → uart_tx=1, empty=1, full=0, busy=0, overflow=0. Assert reset at the 5th data bit of a frame → uart_tx=1 that same cycle (asynchronous) and empty=1.
- Single byte (CLKS_PER_BIT=4): write 0xA5 → uart_tx sequence is 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles. uart_tx falls 1 edge after the write. busy=0 exactly 40 cycles after the fall.
- Back-to-back frames: write 0x00 then 0xFF on consecutive cycles → frames are contiguous, with the start bit of the second frame immediately after the first stop bit. Total 80 cycles.
- Full and overflow (FIFO_AW=2): with the FSM held busy, write 6 bytes in consecutive cycles.
  - The first byte pops at once; the next 4 fill the FIFO and full=1.
  - The 6th write is dropped and overflow=1.
  - Serial output is exactly bytes 1–5 in order.
- Pointer wrap: stream 20 bytes 0x00..0x13 with FIFO_AW=2, writing whenever !full → all 20 are received in order with overflow=0.
- Parity (UART_TX_PARITY_EN defined): 0x07 → parity bit 1; 0x03 → parity bit 0. Each frame is 44 cycles at CLKS_PER_BIT=4.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: byte FIFO from the CPU store path feeding an 8N1 serializer.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop (8E1).
module uart_tx_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_AW      = 4
) (
  input  logic       sysclk,
  input  logic       cpu_resetn,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       overflow,
  output logic       uart_tx
);

  localparam int unsigned Depth      = 2 ** FIFO_AW;
  localparam int unsigned BaudW      = $clog2(CLKS_PER_BIT);
  localparam int unsigned BaudMaxInt = CLKS_PER_BIT - 1;
  localparam logic [BaudW-1:0]   BaudMax  = BaudMaxInt[BaudW-1:0];
  localparam logic [FIFO_AW:0]   DepthCnt = Depth[FIFO_AW:0];

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  // FIFO state
  logic [7:0]         mem_q [Depth];
  logic [FIFO_AW-1:0] wptr_q, wptr_d;
  logic [FIFO_AW-1:0] rptr_q, rptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               push;
  logic               pop;
  logic [7:0]         head;

  // Serializer state
  state_e             state_q, state_d;
  logic [BaudW-1:0]   baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               baud_done;
`ifdef UART_TX_PARITY_EN
  logic               parity_q, parity_d;
`endif

  assign full      = (count_q == DepthCnt);
  assign empty     = (count_q == '0);
  assign push      = wr_en && !full;
  assign head      = mem_q[rptr_q];
  assign baud_done = (baud_q == '0);
  assign overflow  = overflow_q;
  assign uart_tx   = tx_q;
  assign busy      = (state_q != StIdle) || !empty;

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge sysclk) begin
    if (push) begin
      mem_q[wptr_q] <= wr_data;
    end
  end

  // FIFO pointer/count/overflow next-state
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
    // A write while full is dropped even if a pop frees a slot this cycle
    if (wr_en && full) begin
      overflow_d = 1'b1;
    end
  end

  // FIFO bookkeeping registers
  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // FSM state register
  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!empty) state_d = StStart;
      end
      StStart: begin
        if (baud_done) state_d = StData;
      end
      StData: begin
        if (baud_done && (bit_q == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          state_d = StParity;
`else
          state_d = StStop;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (baud_done) state_d = StStop;
      end
`endif
      StStop: begin
        if (baud_done) state_d = empty ? StIdle : StStart;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs and datapath next-state; tx is registered so it changes on the state edge
  always_comb begin
    pop     = 1'b0;
    tx_d    = tx_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    if (state_q != StIdle) begin
      baud_d = baud_done ? BaudMax : baud_q - 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        pop  = !empty;
      end
      StStart: begin
        if (baud_done) begin
          bit_d = 3'd0;
          tx_d  = shift_q[0];
        end
      end
      StData: begin
        if (baud_done) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_d = parity_q;
`else
            tx_d = 1'b1;
`endif
          end else begin
            tx_d = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (baud_done) tx_d = 1'b1;
      end
`endif
      StStop: begin
        if (baud_done) begin
          tx_d   = 1'b1;
          pop    = !empty;
          baud_d = '0;
        end
      end
      default: tx_d = 1'b1;
    endcase
    // Popping a byte always launches a start bit on the same edge
    if (pop) begin
      shift_d = head;
      baud_d  = BaudMax;
      tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d = ^head;
`endif
    end
  end

  // Serializer datapath registers
  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed self-checking bench for uart_tx_ctrl (CLKS_PER_BIT=4, FIFO_AW=2).
module tb_uart_tx_ctrl;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       par;
    logic       stop;
  } frame_t;

  logic       sysclk = 1'b0;
  logic       cpu_resetn;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full, empty, busy, overflow, uart_tx;

  int checks = 0;
  int errors = 0;
  frame_t rx_q[$];

  uart_tx_ctrl #(
    .CLKS_PER_BIT(C),
    .FIFO_AW     (2)
  ) dut (
    .sysclk    (sysclk),
    .cpu_resetn(cpu_resetn),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .busy      (busy),
    .overflow  (overflow),
    .uart_tx   (uart_tx)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge of the first start-bit cycle; checks every cycle of one frame.
  task automatic expect_frame(input logic [7:0] b, input string tag);
    logic e;
    for (int j = 0; j < FB; j++) begin
      if (j == 0) e = 1'b0;
      else if (j <= 8) e = b[j-1];
      else if (j == 9 && FB == 11) e = ^b;
      else e = 1'b1;
      for (int c = 0; c < C; c++) begin
        chk(tag, {31'd0, uart_tx}, {31'd0, e});
        if (j == FB - 1 && c == C - 1) chk({tag, "_busy_last"}, {31'd0, busy}, 32'd1);
        @(negedge sysclk);
      end
    end
  endtask

  // Line monitor: samples mid-bit and queues every frame it sees
  initial begin
    frame_t f;
    forever begin
      @(negedge sysclk);
      if (cpu_resetn === 1'b1 && uart_tx === 1'b0) begin
        f = '0;
        repeat (C / 2) @(negedge sysclk);
        for (int k = 0; k < 8; k++) begin
          repeat (C) @(negedge sysclk);
          f.data[k] = uart_tx;
        end
        if (FB == 11) begin
          repeat (C) @(negedge sysclk);
          f.par = uart_tx;
        end
        repeat (C) @(negedge sysclk);
        f.stop = uart_tx;
        rx_q.push_back(f);
      end
    end
  end

  initial begin
    int n;
    int guard;
    cpu_resetn = 1'b0;
    wr_en      = 1'b0;
    wr_data    = 8'h00;

    // Reset state
    repeat (3) @(negedge sysclk);
    cpu_resetn = 1'b1;
    @(negedge sysclk);
    chk("rst_tx", {31'd0, uart_tx}, 32'd1);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);

    // Single byte 0xA5: fall one edge after the write, busy low 40 cycles after the fall
    wr_en = 1'b1; wr_data = 8'hA5;
    @(negedge sysclk);
    wr_en = 1'b0;
    chk("single_pre_fall_tx", {31'd0, uart_tx}, 32'd1);
    chk("single_pre_fall_empty", {31'd0, empty}, 32'd0);
    @(negedge sysclk);
    expect_frame(8'hA5, "single_a5");
    chk("single_busy_end", {31'd0, busy}, 32'd0);
    chk("single_tx_end", {31'd0, uart_tx}, 32'd1);

    // Back-to-back 0x00 then 0xFF: contiguous frames
    wr_en = 1'b1; wr_data = 8'h00;
    @(negedge sysclk);
    wr_data = 8'hFF;
    chk("b2b_pre_fall_tx", {31'd0, uart_tx}, 32'd1);
    @(negedge sysclk);
    wr_en = 1'b0;
    expect_frame(8'h00, "b2b_first");
    expect_frame(8'hFF, "b2b_second");
    chk("b2b_busy_end", {31'd0, busy}, 32'd0);

`ifdef UART_TX_PARITY_EN
    // 0x07 -> parity 1, 0x03 -> parity 0; 44-cycle frames
    wr_en = 1'b1; wr_data = 8'h07;
    @(negedge sysclk);
    wr_data = 8'h03;
    @(negedge sysclk);
    wr_en = 1'b0;
    expect_frame(8'h07, "par_07");
    expect_frame(8'h03, "par_03");
    chk("par_busy_end", {31'd0, busy}, 32'd0);
`endif

    // Full and overflow: 6 consecutive writes into a depth-4 FIFO
    rx_q.delete();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'h31 + i[7:0];
      @(negedge sysclk);
    end
    chk("ovf_full", {31'd0, full}, 32'd1);
    chk("ovf_not_yet", {31'd0, overflow}, 32'd0);
    wr_data = 8'hEE;
    @(negedge sysclk);
    wr_en = 1'b0;
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    chk("ovf_still_full", {31'd0, full}, 32'd1);
    repeat (6 * FB * C + 20) @(negedge sysclk);
    chk("ovf_rx_count", rx_q.size(), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < rx_q.size()) begin
        chk("ovf_rx_data", {24'd0, rx_q[i].data}, 32'h31 + i);
        chk("ovf_rx_stop", {31'd0, rx_q[i].stop}, 32'd1);
      end
    end
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    chk("ovf_busy_end", {31'd0, busy}, 32'd0);

    // Reset clears sticky overflow
    cpu_resetn = 1'b0;
    repeat (2) @(negedge sysclk);
    cpu_resetn = 1'b1;
    @(negedge sysclk);
    chk("rst2_overflow", {31'd0, overflow}, 32'd0);
    rx_q.delete();

    // Pointer wrap: 20 bytes, writing whenever not full
    n = 0; guard = 0;
    while (n < 20 && guard < 2000) begin
      if (!full) begin
        wr_en = 1'b1; wr_data = n[7:0]; n++;
      end else begin
        wr_en = 1'b0;
      end
      @(negedge sysclk);
      guard++;
    end
    wr_en = 1'b0;
    chk("wrap_all_written", n, 32'd20);
    guard = 0;
    while (rx_q.size() < 20 && guard < 20 * FB * C + 200) begin
      @(negedge sysclk);
      guard++;
    end
    chk("wrap_rx_count", rx_q.size(), 32'd20);
    for (int i = 0; i < 20; i++) begin
      if (i < rx_q.size()) begin
        chk("wrap_rx_data", {24'd0, rx_q[i].data}, i);
        chk("wrap_rx_stop", {31'd0, rx_q[i].stop}, 32'd1);
`ifdef UART_TX_PARITY_EN
        chk("wrap_rx_par", {31'd0, rx_q[i].par}, {31'd0, ^i[7:0]});
`endif
      end
    end
    chk("wrap_overflow", {31'd0, overflow}, 32'd0);
    repeat (2 * C) @(negedge sysclk);
    chk("wrap_busy_end", {31'd0, busy}, 32'd0);

    // Asynchronous reset during the 5th data bit of 0x0F (bit4 = 0) with 0x55 queued
    wr_en = 1'b1; wr_data = 8'h0F;
    @(negedge sysclk);
    wr_data = 8'h55;
    @(negedge sysclk);
    wr_en = 1'b0;
    repeat (5 * C + 1) @(negedge sysclk);
    chk("midrst_pre_tx", {31'd0, uart_tx}, 32'd0);
    chk("midrst_pre_empty", {31'd0, empty}, 32'd0);
    #2 cpu_resetn = 1'b0;
    #1;
    chk("midrst_tx", {31'd0, uart_tx}, 32'd1);
    chk("midrst_empty", {31'd0, empty}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge sysclk);
    cpu_resetn = 1'b1;
    repeat (2) @(negedge sysclk);
    chk("midrst_after_tx", {31'd0, uart_tx}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
